// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with core hold
module imem_loader #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  num_q, num_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        start_ok;
    logic [7:0]  cnt_inc;

    assign start_ok = (num_words != 8'd0) && (32'(num_words) <= MEM_WORDS);
    assign cnt_inc  = cnt_q + 8'd1;

    // Status outputs decode straight from the state so reset clears them at once
    assign in_ready = (state_q == RECV);
    assign wr_en    = (state_q == WRITE);
    assign busy     = (state_q == RECV) || (state_q == WRITE);
    assign cpu_hold = busy;
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= 8'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept/reject start, assemble bytes, step words
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (start_ok) begin
                        num_d   = num_words;
                        cnt_d   = 8'd0;
                        idx_d   = 2'd0;
                        addr_d  = 32'd0;
                        err_d   = 1'b0;
                        state_d = RECV;
                    end else begin
                        // Rejected request keeps the state, so done is untouched
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (in_valid) begin
                    // Bytes arrive LSB first; shifting down lands byte k at [8k+7:8k]
                    data_d = {in_data, data_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == num_q) begin
                    // Address is held on the final word so it never runs past the last slot
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_words = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int hold_gaps = 0;
    int dbl = 0;
    logic prev_we = 1'b0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  bq[$];
    int base;

    imem_loader #(.MEM_WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_words(num_words),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (prev_we) dbl++;
        end
        prev_we = wr_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input int inj);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit injected = 1'b0;
        while (idx < n && cyc < 1000) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = bq[idx];
            if (idx == inj && !injected) begin
                start = 1'b1;
                num_words = 8'd3;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!cpu_hold) hold_gaps++;
            acc = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_w;

        // Reset values, before any clock edge
        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Illegal lengths are rejected and leave the loader idle
        do_start(8'd0);
        check("rej0_err", {31'd0, err}, 32'd1);
        check("rej0_busy", {31'd0, busy}, 32'd0);
        check("rej0_done", {31'd0, done}, 32'd0);
        check("rej0_in_ready", {31'd0, in_ready}, 32'd0);
        do_start(8'd65);
        check("rej65_err", {31'd0, err}, 32'd1);
        check("rej65_busy", {31'd0, busy}, 32'd0);
        check("rej65_writes", 32'(wa_q.size()), 32'd0);

        // Two-word load with in_valid held high; valid start clears err
        base = wa_q.size();
        do_start(8'd2);
        check("t030_err_cleared", {31'd0, err}, 32'd0);
        check("t030_busy", {31'd0, busy}, 32'd1);
        bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        feed(8, 1'b0, -1);
        wait_done("t030_done");
        check("t030_nwrites", 32'(wa_q.size() - base), 32'd2);
        check("t030_addr0", wa_q[base], 32'h0);
        check("t030_data0", wd_q[base], 32'h0000_0513);
        check("t030_addr1", wa_q[base+1], 32'h4);
        check("t030_data1", wd_q[base+1], 32'h0010_0093);
        check("t030_hold", 32'(hold_gaps), 32'd0);
        check("t030_busy_after", {31'd0, busy}, 32'd0);

        // One word with in_valid toggling every cycle
        base = wa_q.size();
        do_start(8'd1);
        bq = '{8'hB7, 8'h02, 8'h00, 8'h80};
        feed(4, 1'b1, -1);
        wait_done("t032_done");
        check("t032_nwrites", 32'(wa_q.size() - base), 32'd1);
        check("t032_addr", wa_q[base], 32'h0);
        check("t032_data", wd_q[base], 32'h8000_02B7);

        // Full-depth load of random bytes against a byte-order model
        base = wa_q.size();
        bq = {};
        for (int i = 0; i < 256; i++) bq.push_back(8'($urandom_range(0, 255)));
        do_start(8'd64);
        feed(256, 1'b0, -1);
        wait_done("t033_done");
        check("t033_nwrites", 32'(wa_q.size() - base), 32'd64);
        for (int w = 0; w < 64; w++) begin
            exp_w = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
            if (base + w < wa_q.size()) begin
                check($sformatf("t033_addr%0d", w), wa_q[base+w], 32'(4 * w));
                check($sformatf("t033_data%0d", w), wd_q[base+w], exp_w);
            end
        end
        check("t033_addr_bound", {31'd0, (wr_addr <= 32'h0000_00FC)}, 32'd1);

        // Reset pulsed mid-load after six of eight bytes
        base = wa_q.size();
        do_start(8'd2);
        bq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        feed(6, 1'b0, -1);
        check("t034_partial_data", {31'd0, (wr_data != 32'd0)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("t034_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        check("t034_nwrites", 32'(wa_q.size() - base), 32'd1);
        check("t034_first_data", wd_q[base], 32'h1122_3344);
        check("t034_idle_busy", {31'd0, busy}, 32'd0);
        base = wa_q.size();
        do_start(8'd2);
        feed(8, 1'b0, -1);
        wait_done("t034_restart_done");
        check("t034_re_nwrites", 32'(wa_q.size() - base), 32'd2);
        check("t034_re_addr1", wa_q[base+1], 32'h4);
        check("t034_re_data1", wd_q[base+1], 32'h5566_7788);

        // start during RECV is ignored; start in DONE restarts from address 0
        base = wa_q.size();
        do_start(8'd2);
        bq = '{8'h01, 8'h00, 8'hAA, 8'hAA, 8'h02, 8'h00, 8'hBB, 8'hBB};
        feed(8, 1'b0, 2);
        wait_done("t035_done");
        repeat (10) @(negedge clk);
        check("t035_nwrites", 32'(wa_q.size() - base), 32'd2);
        check("t035_still_done", {31'd0, done}, 32'd1);
        check("t035_data0", wd_q[base], 32'hAAAA_0001);
        check("t035_data1", wd_q[base+1], 32'hBBBB_0002);
        base = wa_q.size();
        do_start(8'd1);
        check("t035_done_cleared", {31'd0, done}, 32'd0);
        check("t035_restart_busy", {31'd0, busy}, 32'd1);
        check("t035_restart_addr", wr_addr, 32'h0);
        bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        feed(4, 1'b0, -1);
        wait_done("t035_re_done");
        check("t035_re_addr", wa_q[base], 32'h0);
        check("t035_re_data", wd_q[base], 32'hDEAD_BEEF);

        check("single_cycle_wr_en", 32'(dbl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
